// File: rtl/output_port_tx_pkg.sv
// Shared types and field-geometry helpers for the output port transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package output_port_tx_pkg;

    // Staging-register FSM encoding
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_STALL = 2'd1,
        ST_FULL  = 2'd2
    } tx_state_t;

    // Default packet geometry
    localparam int DEF_PACKET_BITS        = 97;
    localparam int DEF_NUM_LEAF_BITS      = 6;
    localparam int DEF_NUM_PORT_BITS      = 4;
    localparam int DEF_NUM_ADDR_BITS      = 7;
    localparam int DEF_PAYLOAD_BITS       = 64;
    localparam int DEF_NUM_BRAM_ADDR_BITS = 7;

    // Zero pad between the sequence number and the payload
    function automatic int pad_width(input int packet_bits, input int leaf_bits,
                                     input int port_bits, input int addr_bits,
                                     input int payload_bits);
        return packet_bits - 1 - leaf_bits - port_bits - addr_bits - payload_bits;
    endfunction

    // Credit counter must hold the full remote depth, hence one extra bit
    function automatic int credit_width(input int bram_addr_bits);
        return bram_addr_bits + 1;
    endfunction

    // Bit offsets, LSB first: payload, pad, seq, port, leaf, valid
    function automatic int seq_lsb(input int payload_bits, input int pad_bits);
        return payload_bits + pad_bits;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; rd_data is the head entry whenever !empty.
// Latency: write at edge N is visible on rd_data/empty after edge N.
// Backpressure: writes ignored when full, reads ignored when empty; full/empty from registered count.
module sync_fifo #(
    parameter int WIDTH     = 64,
    parameter int ADDR_BITS = 2
) (
    input  logic             clk_bft,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_CNT = {1'b1, {ADDR_BITS{1'b0}}};

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [ADDR_BITS:0]   count;
    logic                 do_wr;
    logic                 do_rd;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk_bft) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; reset discards anything buffered
    always_ff @(posedge clk_bft or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/output_port_tx.sv
// Buffers user payload, wraps it in an addressed, sequenced packet and requests the arbiter.
// Latency: user write at edge N -> staged at N+1 -> req high the cycle after N+1.
// Backpressure: ack2user = !fifo_full; staging holds until grant; no issue without remote credit.
module output_port_tx
    import output_port_tx_pkg::*;
#(
    parameter int PACKET_BITS           = 97,
    parameter int NUM_LEAF_BITS         = 6,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int PAYLOAD_BITS          = 64,
    parameter int NUM_BRAM_ADDR_BITS    = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64,
    parameter int FIFO_ADDR_BITS        = 2
) (
    input  logic                          clk_bft,
    input  logic                          reset,
    input  logic [PAYLOAD_BITS-1:0]       din_user,
    input  logic                          vld_user,
    output logic                          ack2user,
    input  logic [NUM_LEAF_BITS-1:0]      dst_leaf,
    input  logic [NUM_PORT_BITS-1:0]      dst_port,
    input  logic                          freespace_update,
    output logic [PACKET_BITS-1:0]        packet_out,
    output logic                          req,
    input  logic                          grant,
    output logic [NUM_BRAM_ADDR_BITS:0]   credit
);

    localparam int PAD_BITS    = pad_width(PACKET_BITS, NUM_LEAF_BITS, NUM_PORT_BITS,
                                           NUM_ADDR_BITS, PAYLOAD_BITS);
    localparam int CREDIT_BITS = credit_width(NUM_BRAM_ADDR_BITS);
    localparam int CSUM_BITS   = CREDIT_BITS + 1;
    localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = {1'b1, {NUM_BRAM_ADDR_BITS{1'b0}}};
    localparam logic [CSUM_BITS-1:0]   FSU_INC    = CSUM_BITS'(FREESPACE_UPDATE_SIZE);

    tx_state_t                 state;
    tx_state_t                 state_nxt;
    logic [NUM_ADDR_BITS-1:0]  seq;
    logic [NUM_ADDR_BITS-1:0]  seq_nxt;
    logic [CSUM_BITS-1:0]      credit_sum;
    logic [CREDIT_BITS-1:0]    credit_nxt;
    logic [PAYLOAD_BITS-1:0]   fifo_dout;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      push;
    logic                      pop;
    logic                      can_load;
    logic                      grant_fire;

    // Held low while reset is asserted so the user never sees a stale ready
    assign ack2user   = reset && !fifo_full;
    assign push       = vld_user && ack2user;
    assign req        = (state == ST_FULL);
    assign can_load   = !fifo_empty && (credit != '0);
    assign grant_fire = (state == ST_FULL) && grant;

    // A packet loaded on the grant edge already carries the advanced number
    assign seq_nxt = seq + NUM_ADDR_BITS'(grant_fire);

    sync_fifo #(
        .WIDTH     (PAYLOAD_BITS),
        .ADDR_BITS (FIFO_ADDR_BITS)
    ) u_fifo (
        .clk_bft (clk_bft),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (din_user),
        .rd_en   (pop),
        .rd_data (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Next staging state; pop doubles as the stage-load strobe
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            ST_FULL: begin
                if (grant) begin
                    if (can_load) begin
                        pop = 1'b1;
                    end else begin
                        state_nxt = fifo_empty ? ST_EMPTY : ST_STALL;
                    end
                end
            end
            default: begin
                if (can_load) begin
                    pop       = 1'b1;
                    state_nxt = ST_FULL;
                end else begin
                    state_nxt = fifo_empty ? ST_EMPTY : ST_STALL;
                end
            end
        endcase
    end

    // Credit: one per load, refund per update, clamp at the remote depth
    always_comb begin
        credit_sum = {1'b0, credit}
                   + (freespace_update ? FSU_INC : '0)
                   - {{CREDIT_BITS{1'b0}}, pop};
        credit_nxt = (credit_sum > {1'b0, CREDIT_MAX}) ? CREDIT_MAX
                                                       : credit_sum[CREDIT_BITS-1:0];
    end

    // FSM state register
    always_ff @(posedge clk_bft or negedge reset) begin
        if (!reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Staging register, sequence number and credit counter
    always_ff @(posedge clk_bft or negedge reset) begin
        if (!reset) begin
            packet_out <= '0;
            seq        <= '0;
            credit     <= CREDIT_MAX;
        end else begin
            seq    <= seq_nxt;
            credit <= credit_nxt;
            if (pop) begin
                packet_out <= {1'b1, dst_leaf, dst_port, seq_nxt,
                               {PAD_BITS{1'b0}}, fifo_dout};
            end
        end
    end

endmodule

// File: tb/tb_output_port_tx.sv
module tb_output_port_tx;

    logic        clk_bft = 1'b0;
    logic        reset;
    logic [63:0] din_user;
    logic        vld_user;
    logic        ack2user;
    logic [5:0]  dst_leaf;
    logic [3:0]  dst_port;
    logic        freespace_update;
    logic [96:0] packet_out;
    logic        req;
    logic        grant;
    logic [7:0]  credit;

    int checks = 0;
    int errors = 0;
    int sent   = 0;
    logic mon_en = 1'b0;

    always #5 clk_bft = ~clk_bft;

    output_port_tx dut (
        .clk_bft          (clk_bft),
        .reset            (reset),
        .din_user         (din_user),
        .vld_user         (vld_user),
        .ack2user         (ack2user),
        .dst_leaf         (dst_leaf),
        .dst_port         (dst_port),
        .freespace_update (freespace_update),
        .packet_out       (packet_out),
        .req              (req),
        .grant            (grant),
        .credit           (credit)
    );

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [96:0] pkt(input logic [5:0] l, input logic [3:0] p,
                                        input logic [6:0] s, input logic [63:0] d);
        return {1'b1, l, p, s, 15'b0, d};
    endfunction

    task automatic tick();
        @(posedge clk_bft);
        #1;
    endtask

    task automatic do_reset();
        reset            = 1'b0;
        vld_user         = 1'b0;
        freespace_update = 1'b0;
        grant            = 1'b0;
        repeat (2) @(posedge clk_bft);
        #1;
        reset = 1'b1;
    endtask

    // Presents one word for exactly one edge; returns 1ns after that edge
    task automatic write_one(input logic [63:0] d);
        din_user = d;
        vld_user = 1'b1;
        tick();
        vld_user = 1'b0;
    endtask

    // Writes payloads 0..n-1 as fast as ack2user allows, bounded by a cycle budget
    task automatic stream(input int n, input int limit);
        int   i;
        int   cyc;
        logic w;
        i   = 0;
        cyc = 0;
        while (i < n && cyc < limit) begin
            din_user = 64'(i);
            vld_user = 1'b1;
            @(negedge clk_bft);
            w = ack2user;
            @(posedge clk_bft);
            #1;
            cyc++;
            if (w) i++;
        end
        vld_user = 1'b0;
    endtask

    // Packet checker: contiguous seq (mod 128) and in-order payload; plus credit overflow guard
    always @(negedge clk_bft) begin
        if (mon_en && reset && req && grant) begin
            check("stream_pkt", 128'(packet_out),
                  128'(pkt(dst_leaf, dst_port, sent[6:0], 64'(sent))));
            sent++;
        end
        if (reset && freespace_update) begin
            check("fsu_no_overflow", 128'(credit <= 8'd64), 128'(1'b1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        reset            = 1'b0;
        din_user         = '0;
        vld_user         = 1'b0;
        dst_leaf         = '0;
        dst_port         = '0;
        freespace_update = 1'b0;
        grant            = 1'b0;

        // Reset values
        #12;
        check("rst_packet", 128'(packet_out), 128'(0));
        check("rst_req",    128'(req),        128'(0));
        check("rst_ack",    128'(ack2user),   128'(0));
        check("rst_credit", 128'(credit),     128'(128));

        // First packet: latency, format, credit decrement; grant high while idle is ignored
        tick();
        reset    = 1'b1;
        grant    = 1'b1;
        dst_leaf = 6'd3;
        dst_port = 4'd2;
        tick();
        check("ack_after_rst", 128'(ack2user), 128'(1));
        write_one(64'h1);
        @(negedge clk_bft);
        check("req_not_yet", 128'(req), 128'(0));
        @(negedge clk_bft);
        check("first_req",    128'(req),        128'(1));
        check("first_packet", 128'(packet_out), 128'(pkt(6'd3, 4'd2, 7'd0, 64'h1)));
        check("first_credit", 128'(credit),     128'(127));
        @(negedge clk_bft);
        check("req_after_grant", 128'(req), 128'(0));

        // Hold with grant low: staged packet stable despite dst change, then reload on grant
        grant    = 1'b0;
        dst_leaf = 6'd5;
        dst_port = 4'd7;
        write_one(64'hAA);
        tick();
        dst_leaf = 6'd9;
        write_one(64'hBB);
        repeat (10) tick();
        @(negedge clk_bft);
        check("hold_req",    128'(req),        128'(1));
        check("hold_packet", 128'(packet_out), 128'(pkt(6'd5, 4'd7, 7'd1, 64'hAA)));
        check("hold_credit", 128'(credit),     128'(126));
        @(posedge clk_bft);
        #1;
        grant = 1'b1;
        tick();
        grant = 1'b0;
        @(negedge clk_bft);
        check("reload_packet", 128'(packet_out), 128'(pkt(6'd9, 4'd7, 7'd2, 64'hBB)));
        check("reload_req",    128'(req),        128'(1));
        check("reload_credit", 128'(credit),     128'(125));

        // Stream 200 words: 128 at full rate, stall on credit, one update frees 64 more (seq wraps)
        do_reset();
        dst_leaf = 6'd1;
        dst_port = 4'd4;
        grant    = 1'b1;
        sent     = 0;
        mon_en   = 1'b1;
        fork
            stream(200, 520);
            begin
                repeat (135) @(posedge clk_bft);
                @(negedge clk_bft);
                check("rate_sent", 128'(sent), 128'(128));
                repeat (165) @(posedge clk_bft);
                @(negedge clk_bft);
                check("stall_sent",   128'(sent),     128'(128));
                check("stall_req",    128'(req),      128'(0));
                check("stall_credit", 128'(credit),   128'(0));
                check("stall_ack",    128'(ack2user), 128'(0));
                @(posedge clk_bft);
                #1;
                freespace_update = 1'b1;
                @(posedge clk_bft);
                #1;
                freespace_update = 1'b0;
                repeat (200) @(posedge clk_bft);
                @(negedge clk_bft);
                check("update_sent",   128'(sent),   128'(192));
                check("update_credit", 128'(credit), 128'(0));
                check("update_req",    128'(req),    128'(0));
            end
        join
        mon_en = 1'b0;

        // Update coincident with a stage load at credit 5
        do_reset();
        dst_leaf = 6'd2;
        dst_port = 4'd1;
        grant    = 1'b1;
        sent     = 0;
        mon_en   = 1'b1;
        stream(123, 300);
        repeat (5) tick();
        mon_en = 1'b0;
        check("c5_sent",   128'(sent),   128'(123));
        check("c5_credit", 128'(credit), 128'(5));
        grant    = 1'b0;
        din_user = 64'h77;
        vld_user = 1'b1;
        tick();
        vld_user         = 1'b0;
        freespace_update = 1'b1;
        tick();
        freespace_update = 1'b0;
        @(negedge clk_bft);
        check("c5_coincident", 128'(credit),     128'(68));
        check("c5_packet",     128'(packet_out), 128'(pkt(6'd2, 4'd1, 7'd123, 64'h77)));

        // Reset mid-operation: outputs drop immediately, buffered data discarded
        do_reset();
        dst_leaf = 6'd6;
        dst_port = 4'd3;
        write_one(64'h11);
        write_one(64'h22);
        @(negedge clk_bft);
        check("pre_rst_req", 128'(req), 128'(1));
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_req",    128'(req),        128'(0));
        check("mid_rst_packet", 128'(packet_out), 128'(0));
        check("mid_rst_ack",    128'(ack2user),   128'(0));
        check("mid_rst_credit", 128'(credit),     128'(128));
        @(posedge clk_bft);
        #1;
        reset = 1'b1;
        grant = 1'b1;
        write_one(64'h33);
        @(posedge clk_bft);
        @(negedge clk_bft);
        check("post_rst_packet", 128'(packet_out), 128'(pkt(6'd6, 4'd3, 7'd0, 64'h33)));
        check("post_rst_credit", 128'(credit),     128'(127));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
